// File: rtl/sqrt_operand_dr_tx.sv
// Single-rail to dual-rail four-phase operand transmitter for the async sqrt core.
// Optional watchdog is enabled by defining SQRT_OPERAND_TX_TIMEOUT_EN.
module sqrt_operand_dr_tx #(
    parameter int EW             = 7,
    parameter int RW             = 29,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [EW:0]              in_exp_i,
    input  logic [RW:0]              in_radicand_i,
    output logic [2*(EW+RW+2)-1:0]   op_o,
    input  logic                     ack_i,
    output logic                     busy_o,
    output logic                     timeout_o
);

    localparam int NP = EW + RW + 2;

    typedef enum logic [1:0] {IDLE, DATA, RTZ} state_t;

    state_t                 state_q, state_d;
    logic [2*NP-1:0]        op_q, op_d, op_enc;
    logic                   ready_q, ready_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   ack_s;
    logic                   accept;
    logic                   expired;

    // Per bit: data_0 on the odd rail, data_1 on the even rail.
    always_comb begin
        op_enc = '0;
        for (int i = 0; i <= RW; i++) begin
            op_enc[2*i +: 2] = in_radicand_i[i] ? 2'b01 : 2'b10;
        end
        for (int j = 0; j <= EW; j++) begin
            op_enc[2*(RW+1+j) +: 2] = in_exp_i[j] ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], ack_i};
    end

    assign ack_s  = sync_q[SYNC_STAGES-1];
    assign accept = in_valid_i & ready_q;

`ifdef SQRT_OPERAND_TX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    assign expired = (state_q != IDLE) &&
                     (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Restart the count on every entry into DATA or RTZ.
    always_comb begin
        cnt_d     = '0;
        timeout_d = timeout_q | expired;
        if (state_q != IDLE && state_d == state_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign expired   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ready_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = op_enc;
                    state_d = DATA;
                end else begin
                    ready_d = ~ack_s;
                end
            end
            DATA: begin
                if (expired) begin
                    op_d    = '0;
                    state_d = IDLE;
                    ready_d = ~ack_s;
                end else if (ack_s) begin
                    op_d    = '0;
                    state_d = RTZ;
                end
            end
            RTZ: begin
                if (expired || !ack_s) begin
                    state_d = IDLE;
                    ready_d = ~ack_s;
                end
            end
            default: begin
                op_d    = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            ready_q <= 1'b0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ready_q <= ready_d;
            sync_q  <= sync_d;
        end
    end

    assign op_o       = op_q;
    assign in_ready_o = ready_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: doc/sqrt_operand_dr_tx.md
Name: sqrt_operand_dr_tx

Overview:
- Synchronous-side transmitter that feeds operands into the asynchronous square-root CORDIC core.
- Accepts a single-rail exponent/radicand pair over a valid/ready handshake.
- Drives the pair onto the core's dual-rail operand bus (operand_t layout) using a four-phase return-to-zero protocol, closed by the core's completion acknowledge.
- Sits between the clocked front end and the async core input.

Parameters:
- EW, 7, exponent MSB index (exponent width EW+1)
- RW, 29, radicand MSB index (radicand width RW+1)
- SYNC_STAGES, 2, flop stages on the ack_i synchronizer (min 2)
- TIMEOUT_CYCLES, 1023, watchdog limit in clk cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid_i  in  1  operand valid
- in_ready_o  out  1  operand accepted when in_valid_i & in_ready_o
- in_exp_i  in  EW+1  single-rail exponent
- in_radicand_i  in  RW+1  single-rail radicand
- op_o  out  2*(EW+RW+2)  dual-rail operand bus; exp pairs in the upper bits, radicand pairs in the lower bits
- ack_i  in  1  asynchronous completion acknowledge from the core
- busy_o  out  1  high while a transfer is in flight (state != IDLE)
- timeout_o  out  1  sticky watchdog flag

Behaviour:
- Clocking and reset:
  - One clock (clk).
  - Reset is synchronous and active-low (rst_n); it is sampled only on the rising edge of clk.
- Encoding, per bit b at pair index k:
  - op_o[2k+1] = data_0, op_o[2k] = data_1.
  - b=1 drives 01; b=0 drives 10; spacer is 00; 11 is never driven.
  - Radicand bit i maps to pair k=i.
  - Exponent bit j maps to pair k=RW+1+j.
- op_o is driven only from flops (glitch-free). Each transition is either all-spacer to full codeword, or codeword to all-spacer, in one clock edge.
- ack synchronizer:
  - ack_i passes through SYNC_STAGES flops to give ack_s.
  - The synchronizer flops reset to 0.
- Reset values: op_o=0 (spacer), in_ready_o=0, busy_o=0, timeout_o=0, state=IDLE.
- FSM states: IDLE, DATA, RTZ.
- IDLE:
  - in_ready_o = (ack_s==0), registered.
  - On accept: latch the encoded operand into op_o on the same edge, go to DATA. The codeword is visible the cycle after the accept (latency 1).
  - in_ready_o drops the cycle after the accept.
- DATA:
  - Hold the codeword.
  - When ack_s==1: op_o goes to spacer on the next edge; go to RTZ.
- RTZ:
  - Hold the spacer.
  - When ack_s==0: go to IDLE; in_ready_o rises on that same edge.
- Throughput: at most one operand per full four-phase cycle. The minimum cycle time is 2*SYNC_STAGES+3 clocks, given an immediate ack.
- Boundary conditions:
  - in_valid_i while busy is ignored; no buffering.
  - If ack_s is already 1 when IDLE is entered (e.g. after a reset mid-transfer), in_ready_o stays 0 until ack_s==0.
  - A reset mid-transfer forces spacer on the next edge.
  - An ack_s glitch back to 0 in DATA before being seen high has no effect.
  - ack_s rising during IDLE is ignored, but it blocks in_ready_o.

Optional Feature:
- Macro: SQRT_OPERAND_TX_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to DATA or RTZ and increments every cycle spent in those states.
  - Reaching TIMEOUT_CYCLES sets timeout_o (sticky until reset).
  - The FSM forces spacer and returns to IDLE, still obeying the ack_s==0 gate for in_ready_o.
- When undefined:
  - No counter logic.
  - timeout_o is tied 0.
  - The FSM waits indefinitely.

Test Plan:
- Reset check: hold rst_n=0 for 3 clk with ack_i=0, then release -> op_o=0, busy_o=0, timeout_o=0 during reset; in_ready_o=1 on the first edge after release.
- Single transfer: in_exp_i=8'h81, in_radicand_i=30'h0400_0000, accepted at cycle N.
  - At N+1: op_o[53:52]=01, op_o[61:60]=01, op_o[75:74]=01, all other pairs 10, busy_o=1.
  - Assert ack_i -> op_o=0 SYNC_STAGES+1 cycles later.
  - Drop ack_i -> in_ready_o=1 SYNC_STAGES+1 cycles later.
- Back-to-back: hold in_valid_i=1 with operands A=(8'h00, 30'h3FFF_FFFF) then B=(8'hFF, 30'h0), core model acks after 4 cycles.
  - A encodes as all radicand pairs 01 and exp pairs 10; B encodes as the inverse.
  - A spacer cycle separates the two codewords; no pair is ever 11.
- Stall: keep ack_i=0 for 200 cycles after the codeword -> op_o stable, in_ready_o=0, new in_valid_i ignored.
- Reset during DATA with ack_i=1 held -> op_o=0 after the reset edge; in_ready_o stays 0 until ack_i=0 has propagated through the synchronizer.
- With SQRT_OPERAND_TX_TIMEOUT_EN and TIMEOUT_CYCLES=16, never ack -> timeout_o=1 16 cycles after DATA entry, op_o=0, flag sticky; with the macro undefined the same stimulus leaves timeout_o=0.
